// File: rtl/stopwatch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_seq_ctrl
// Description : MM:SS up/down stopwatch/timer controller. One shared
//               modulo-L increment/decrement step serves both user edits and
//               periodic ticks. Carries and borrows ripple one digit per
//               clock. Also sequences start/stop, clear and countdown expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_seq_ctrl #(
  parameter int L0 = 10,
  parameter int L1 = 6,
  parameter int L2 = 10,
  parameter int L3 = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        dir,
  input  logic        edit_inc,
  input  logic        edit_dec,
  input  logic [1:0]  edit_sel,
  output logic [15:0] digits,
  output logic        running,
  output logic        busy,
  output logic        expired,
  output logic        wrap
);

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [4:0] c_MOD0 = 5'(L0);
  localparam logic [4:0] c_MOD1 = 5'(L1);
  localparam logic [4:0] c_MOD2 = 5'(L2);
  localparam logic [4:0] c_MOD3 = 5'(L3);
  localparam logic [3:0] c_MAX0 = 4'(L0 - 1);
  localparam logic [3:0] c_MAX1 = 4'(L1 - 1);
  localparam logic [3:0] c_MAX2 = 4'(L2 - 1);
  localparam logic [3:0] c_MAX3 = 4'(L3 - 1);

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [1:0]  idx_q, idx_d;
  logic        step_dir_q, step_dir_d;
  logic        pend_q, pend_d;
  logic        stop_req_q, stop_req_d;
  logic        wrap_q, wrap_d;

  // Shared step datapath signals
  logic [1:0]  step_k;
  logic        step_inc;
  logic        step_dec;
  logic [3:0]  step_a;
  logic [4:0]  step_z;
  logic [4:0]  step_mod;
  logic [3:0]  step_max;
  logic [3:0]  step_res;
  logic        step_carry;
  logic        step_borrow;

  // Shared modulo-L step: STEP owns it, otherwise it serves the edit port
  always_comb begin
    step_k   = edit_sel;
    step_inc = edit_inc;
    step_dec = edit_dec;
    if (state_q == ST_STEP) begin
      step_k   = idx_q;
      step_inc = ~step_dir_q;
      step_dec = step_dir_q;
    end
    step_a = digits_q[{step_k, 2'b00} +: 4];
    case (step_k)
      2'd0:    begin step_mod = c_MOD0; step_max = c_MAX0; end
      2'd1:    begin step_mod = c_MOD1; step_max = c_MAX1; end
      2'd2:    begin step_mod = c_MOD2; step_max = c_MAX2; end
      default: begin step_mod = c_MOD3; step_max = c_MAX3; end
    endcase
    step_z      = {1'b0, step_a} + {4'b0000, step_inc} - {4'b0000, step_dec};
    step_res    = step_a;
    step_carry  = 1'b0;
    step_borrow = 1'b0;
    if (step_inc && step_dec) begin
      step_res = step_a;
    end else if (step_dec && (step_a == 4'd0)) begin
      step_res    = step_max;
      step_borrow = 1'b1;
    end else if (step_z >= step_mod) begin
      step_res   = 4'd0;
      step_carry = 1'b1;
    end else begin
      step_res = step_z[3:0];
    end
  end

  // Next-state logic for the sequencer and digit register
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    idx_d      = idx_q;
    step_dir_d = step_dir_q;
    pend_d     = pend_q;
    stop_req_d = stop_req_q;
    wrap_d     = 1'b0;

    if (clear) begin
      state_d    = ST_STOP;
      digits_d   = 16'h0000;
      idx_d      = 2'd0;
      pend_d     = 1'b0;
      stop_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (start_stop) begin
            // Starting a countdown from zero has nothing to count
            state_d = (dir && (digits_q == 16'h0000)) ? ST_EXPIRED : ST_RUN;
          end else if (edit_inc || edit_dec) begin
            digits_d[{step_k, 2'b00} +: 4] = step_res;
          end
        end

        ST_RUN: begin
          if (start_stop) begin
            // A tick coinciding with the stop is dropped
            state_d = ST_STOP;
            pend_d  = 1'b0;
          end else if (tick || pend_q) begin
            state_d    = ST_STEP;
            idx_d      = 2'd0;
            step_dir_d = dir;
            pend_d     = 1'b0;
            stop_req_d = 1'b0;
          end
        end

        ST_STEP: begin
          digits_d[{step_k, 2'b00} +: 4] = step_res;
          if (tick) begin
            pend_d = 1'b1;
          end
          if ((step_carry || step_borrow) && (idx_q != 2'd3)) begin
            idx_d = idx_q + 2'd1;
            if (start_stop) begin
              stop_req_d = 1'b1;
            end
          end else begin
            // Step complete; a carry out of the top digit is a full wrap
            wrap_d     = step_carry && (idx_q == 2'd3);
            idx_d      = 2'd0;
            stop_req_d = 1'b0;
            if (stop_req_q || start_stop) begin
              state_d = ST_STOP;
              pend_d  = 1'b0;
            end else if (step_dir_q && (digits_d == 16'h0000)) begin
              state_d = ST_EXPIRED;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_RUN;
            end
          end
        end

        default: begin
          if (start_stop) begin
            state_d = ST_STOP;
          end
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_STOP;
      digits_q   <= 16'h0000;
      idx_q      <= 2'd0;
      step_dir_q <= 1'b0;
      pend_q     <= 1'b0;
      stop_req_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      idx_q      <= idx_d;
      step_dir_q <= step_dir_d;
      pend_q     <= pend_d;
      stop_req_q <= stop_req_d;
      wrap_q     <= wrap_d;
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign busy    = (state_q == ST_STEP);
  assign expired = (state_q == ST_EXPIRED);
  assign wrap    = wrap_q;

endmodule
`default_nettype wire
